// File: rtl/intr_ctrl_pkg.sv
// ============================================================================
//  Module   : intr_ctrl_pkg
//  Purpose  : Shared FSM state encoding and default sizing for intr_ctrl.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package intr_ctrl_pkg;

    localparam int INTR_N_SRC = 4;
    localparam int INTR_ID_W  = 2;

    typedef enum logic [1:0] {
        INTR_IDLE    = 2'd0,
        INTR_REQ     = 2'd1,
        INTR_SERVICE = 2'd2
    } intr_state_e;

endpackage

`default_nettype wire

// File: rtl/intr_ctrl_if.sv
// ============================================================================
//  Module   : intr_ctrl_if
//  Purpose  : CPU/peripheral-facing signal bundle of the interrupt controller.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface intr_ctrl_if
    import intr_ctrl_pkg::*;
#(
    parameter int N_SRC   = INTR_N_SRC,
    parameter int ID_W    = INTR_ID_W,
    parameter int TIMER_W = 32
);
    logic [N_SRC-1:0]   src_pulse;
    logic               intr_en;
    logic               mask_we;
    logic [N_SRC-1:0]   mask_wdata;
    logic               timer_we;
    logic [TIMER_W-1:0] timer_wdata;
    logic               intr_ack;
    logic               intr_done;
    logic               intr_req;
    logic [ID_W-1:0]    intr_id;
    logic [N_SRC-1:0]   pending;
    logic [N_SRC-1:0]   mask;

    modport master (
        output src_pulse, intr_en, mask_we, mask_wdata, timer_we, timer_wdata,
               intr_ack, intr_done,
        input  intr_req, intr_id, pending, mask
    );

    modport slave (
        input  src_pulse, intr_en, mask_we, mask_wdata, timer_we, timer_wdata,
               intr_ack, intr_done,
        output intr_req, intr_id, pending, mask
    );
endinterface

`default_nettype wire

// File: rtl/intr_prio_enc.sv
// ============================================================================
//  Module   : intr_prio_enc
//  Purpose  : Lowest-index-wins priority encoder with a valid flag.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module intr_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    // Scan high to low so the last hit, the lowest index, wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/intr_ctrl.sv
// ============================================================================
//  Module   : intr_ctrl
//  Purpose  : Pending/mask latch, fixed-priority arbiter and req/ack/done
//             handshake towards the CPU. Optional periodic timer source on
//             the highest index, enabled with `define INTR_TIMER_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int N_SRC   = INTR_N_SRC,
    parameter int ID_W    = INTR_ID_W,
    parameter int TIMER_W = 32
) (
    input  logic      clk,
    input  logic      reset,
    intr_ctrl_if.slave bus
);

    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [ID_W-1:0]  id_q, id_d;
    intr_state_e      state_q, state_d;

    logic [N_SRC-1:0] w_src;
    logic [N_SRC-1:0] w_cand;
    logic [N_SRC-1:0] w_clr;
    logic [ID_W-1:0]  w_win;
    logic             w_win_vld;
    logic             w_timer_pulse;

`ifdef INTR_TIMER_EN
    logic [TIMER_W-1:0] cnt_q, cnt_d;
    logic [TIMER_W-1:0] period_q, period_d;

    // A period write restarts the count and suppresses a coincident wrap.
    always_comb begin
        cnt_d         = cnt_q;
        period_d      = period_q;
        w_timer_pulse = 1'b0;
        if (bus.timer_we) begin
            period_d = bus.timer_wdata;
            cnt_d    = '0;
        end else if (period_q != '0) begin
            if (cnt_q == period_q - TIMER_W'(1)) begin
                cnt_d         = '0;
                w_timer_pulse = 1'b1;
            end else begin
                cnt_d = cnt_q + TIMER_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            period_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end
`else
    logic w_unused_timer;
    assign w_unused_timer = ^{bus.timer_we, bus.timer_wdata};
    assign w_timer_pulse  = 1'b0;
`endif

    assign w_src  = bus.src_pulse | {w_timer_pulse, {(N_SRC-1){1'b0}}};
    assign w_cand = pending_q & mask_q;

    intr_prio_enc #(
        .N (N_SRC),
        .W (ID_W)
    ) u_prio (
        .req_i   (w_cand),
        .idx_o   (w_win),
        .valid_o (w_win_vld)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        w_clr   = '0;
        unique case (state_q)
            INTR_IDLE: begin
                if (bus.intr_en && w_win_vld) begin
                    state_d = INTR_REQ;
                    id_d    = w_win;
                end
            end
            INTR_REQ: begin
                // Ack beats withdrawal when both happen in the same cycle.
                if (bus.intr_ack) begin
                    state_d = INTR_SERVICE;
                    w_clr   = {{(N_SRC-1){1'b0}}, 1'b1} << id_q;
                end else if (!bus.intr_en || !mask_q[id_q]) begin
                    state_d = INTR_IDLE;
                end
            end
            INTR_SERVICE: begin
                if (bus.intr_done) begin
                    state_d = INTR_IDLE;
                end
            end
            default: state_d = INTR_IDLE;
        endcase
    end

    // New events are OR-ed in after the clear so a same-cycle event survives.
    assign pending_d = (pending_q & ~w_clr) | w_src;
    assign mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INTR_IDLE;
            id_q      <= '0;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    assign bus.intr_req = (state_q == INTR_REQ);
    assign bus.intr_id  = id_q;
    assign bus.pending  = pending_q;
    assign bus.mask     = mask_q;

endmodule

`default_nettype wire

// File: tb/tb_intr_ctrl.sv
// ============================================================================
//  Module   : tb_intr_ctrl
//  Purpose  : Directed scenarios plus random traffic against a cycle model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_intr_ctrl;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TW = 32;

    logic clk = 1'b0;
    logic reset;

    intr_ctrl_if #(.N_SRC(N), .ID_W(IW), .TIMER_W(TW)) bus ();

    intr_ctrl #(.N_SRC(N), .ID_W(IW), .TIMER_W(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: protocol phase flags, pending/mask bit vectors, timer.
    bit [N-1:0]  m_pend, m_mask;
    bit          m_req, m_svc;
    int          m_id;
    bit [TW-1:0] m_tcnt, m_tper;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit [N-1:0] pulse, input bit en,
                              input bit mwe, input bit [N-1:0] mwd, input bit ack,
                              input bit done, input bit twe, input bit [TW-1:0] twd);
        bit [N-1:0] cand, clr, ev;
        if (rst) begin
            m_pend = '0; m_mask = '0; m_req = 0; m_svc = 0; m_id = 0;
            m_tcnt = '0; m_tper = '0;
            return;
        end
        ev = pulse;
`ifdef INTR_TIMER_EN
        if (twe) begin
            m_tper = twd; m_tcnt = '0;
        end else if (m_tper != 0) begin
            if (m_tcnt + 1 == m_tper) begin
                m_tcnt = '0; ev[N-1] = 1'b1;
            end else begin
                m_tcnt = m_tcnt + 1;
            end
        end
`endif
        cand = m_pend & m_mask;
        clr  = '0;
        if (m_req) begin
            if (ack) begin
                m_req = 0; m_svc = 1; clr[m_id] = 1'b1;
            end else if (!en || !m_mask[m_id]) begin
                m_req = 0;
            end
        end else if (m_svc) begin
            if (done) m_svc = 0;
        end else if (en && cand != 0) begin
            m_req = 1;
            for (int i = 0; i < N; i++) begin
                if (cand[i]) begin
                    m_id = i;
                    break;
                end
            end
        end
        m_pend = (m_pend & ~clr) | ev;
        if (mwe) m_mask = mwd;
    endtask

    // One clock: model follows the inputs present at the edge, outputs checked 1ns later.
    task automatic tick();
        bit rst, en, mwe, ack, done, twe;
        bit [N-1:0] p, mwd;
        bit [TW-1:0] twd;
        rst = reset; p = bus.src_pulse; en = bus.intr_en; mwe = bus.mask_we;
        mwd = bus.mask_wdata; ack = bus.intr_ack; done = bus.intr_done;
        twe = bus.timer_we; twd = bus.timer_wdata;
        @(posedge clk);
        model_step(rst, p, en, mwe, mwd, ack, done, twe, twd);
        #1;
        check("req",  32'(bus.intr_req), 32'(m_req));
        check("id",   32'(bus.intr_id),  32'(m_id));
        check("pend", 32'(bus.pending),  32'(m_pend));
        check("mask", 32'(bus.mask),     32'(m_mask));
    endtask

    task automatic clear_strobes();
        bus.src_pulse = '0; bus.mask_we = 0; bus.intr_ack = 0;
        bus.intr_done = 0; bus.timer_we = 0;
    endtask

    task automatic write_mask(input bit [N-1:0] m);
        bus.mask_we = 1; bus.mask_wdata = m; tick(); bus.mask_we = 0;
    endtask

    task automatic pulse(input bit [N-1:0] p);
        bus.src_pulse = p; tick(); bus.src_pulse = '0;
    endtask

    task automatic ack_done();
        bus.intr_ack = 1; tick(); bus.intr_ack = 0;
        bus.intr_done = 1; tick(); bus.intr_done = 0;
    endtask

    initial begin
        reset = 1; bus.intr_en = 0; bus.mask_wdata = '0; bus.timer_wdata = '0;
        clear_strobes();
        m_pend = '0; m_mask = '0; m_req = 0; m_svc = 0; m_id = 0; m_tcnt = '0; m_tper = '0;
        tick(); tick();
        reset = 0;
        check("rst_req",  32'(bus.intr_req), 0);
        check("rst_pend", 32'(bus.pending), 0);

        // Single source, basic handshake.
        write_mask(4'b1111); bus.intr_en = 1;
        pulse(4'b0100);
        check("p2_pend", 32'(bus.pending), 32'h4);
        check("p2_noreq", 32'(bus.intr_req), 0);
        tick();
        check("p2_req", 32'(bus.intr_req), 1);
        check("p2_id",  32'(bus.intr_id), 2);
        bus.intr_ack = 1; tick(); bus.intr_ack = 0;
        check("p2_ack_pend", 32'(bus.pending), 0);
        check("p2_ack_req",  32'(bus.intr_req), 0);
        bus.intr_done = 1; tick(); bus.intr_done = 0;

        // Two sources together: lowest index first, then the other after the gap.
        pulse(4'b1010); tick();
        check("pri_id1", 32'(bus.intr_id), 1);
        ack_done();
        check("gap_noreq", 32'(bus.intr_req), 0);
        tick();
        check("gap_req", 32'(bus.intr_req), 1);
        check("gap_id3", 32'(bus.intr_id), 3);
        ack_done();

        // Masked source stays pending until unmasked.
        write_mask(4'b0000);
        pulse(4'b0001); tick();
        check("msk_pend", 32'(bus.pending), 32'h1);
        check("msk_noreq", 32'(bus.intr_req), 0);
        write_mask(4'b0001); tick();
        check("unmsk_req", 32'(bus.intr_req), 1);
        check("unmsk_id",  32'(bus.intr_id), 0);
        ack_done();

        // Global enable gating and withdrawal.
        bus.intr_en = 0; write_mask(4'b1111);
        pulse(4'b0010); tick(); tick();
        check("en0_noreq", 32'(bus.intr_req), 0);
        bus.intr_en = 1; tick();
        check("en1_req", 32'(bus.intr_req), 1);
        bus.intr_en = 0; tick();
        check("wd_req",  32'(bus.intr_req), 0);
        check("wd_pend", 32'(bus.pending[1]), 1);
        bus.intr_en = 1; tick(); ack_done();

        // Event on the acked source survives; reset during service.
        pulse(4'b0100); tick();
        bus.intr_ack = 1; bus.src_pulse = 4'b0100; tick();
        bus.intr_ack = 0; bus.src_pulse = '0;
        check("keep_pend2", 32'(bus.pending[2]), 1);
        reset = 1; tick(); reset = 0;
        check("svc_rst_pend", 32'(bus.pending), 0);
        check("svc_rst_mask", 32'(bus.mask), 0);

        // Random traffic, including stray ack/done outside their phases.
        for (int c = 0; c < 600; c++) begin
            bus.src_pulse  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            bus.intr_en    = ($urandom_range(0, 7) != 0);
            bus.mask_we    = ($urandom_range(0, 9) == 0);
            bus.mask_wdata = N'($urandom);
            bus.intr_ack   = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            bus.intr_done  = m_svc ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            bus.timer_we   = 0;
            reset          = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 0; clear_strobes();

`ifdef INTR_TIMER_EN
        reset = 1; tick(); reset = 0;
        bus.intr_en = 0; write_mask(4'b1000);
        bus.timer_we = 1; bus.timer_wdata = 10; tick(); bus.timer_we = 0;
        for (int c = 0; c < 9; c++) tick();
        check("tmr_before", 32'(bus.pending[3]), 0);
        tick();
        check("tmr_fire", 32'(bus.pending[3]), 1);
        bus.intr_en = 1; tick(); ack_done();
        bus.timer_we = 1; bus.timer_wdata = 0; tick(); bus.timer_we = 0;
        for (int c = 0; c < 25; c++) tick();
        check("tmr_stop", 32'(bus.pending[3]), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/intr_ctrl.md
# intr_ctrl

Interrupt controller that sits directly upstream of the CPU's interrupt registers (`intr_en`, `intr_vec`). It latches pulse events from peripheral sources (UART rx, timer, …) into a pending register and applies a software mask. It arbitrates by fixed priority and presents one request at a time to the CPU over a req/ack handshake. It holds off further requests until the CPU signals end of service.

## Interface
- `N_SRC`, default 4: number of interrupt sources, 2..16.
- `ID_W`, default 2: width of source id; must satisfy 2**ID_W >= N_SRC.
- `TIMER_W`, default 32: width of built-in timer counter (used only with `INTR_TIMER_EN`).

- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `src_pulse`  in  N_SRC  one-cycle event pulses; a high level holds the bit set every cycle.
- `intr_en`  in  1  CPU global interrupt enable (`sr.intr_en`).
- `mask_we`  in  1  write strobe for mask register.
- `mask_wdata`  in  N_SRC  new mask; 1 = source enabled.
- `timer_we`  in  1  write strobe for timer period.
- `timer_wdata`  in  TIMER_W  new timer period.
- `intr_ack`  in  1  CPU accepted request (vector taken).
- `intr_done`  in  1  CPU finished handler (return-from-interrupt).
- `intr_req`  out  1  request to CPU.
- `intr_id`  out  ID_W  id of requested/in-service source.
- `pending`  out  N_SRC  pending register, readable by CPU.
- `mask`  out  N_SRC  mask register.

## Operation
- Reset values: `pending`=0, `mask`=0, `intr_req`=0, `intr_id`=0, state IDLE, timer count 0, period 0.
- Pending: `pending[i]` is set in any cycle where `src_pulse[i]`=1. It is cleared when an ack is accepted for id i. A simultaneous set and clear on the same bit leaves it set, so no event is lost.
- Mask: written on `mask_we`, taking effect the next cycle. Masking never clears pending.
- Candidate = `pending & mask`. Winner = lowest set index, which has the highest priority.
- FSM:
  - IDLE -> REQ when `intr_en` && candidate≠0. On this transition `intr_id` is registered from the winner.
  - REQ: `intr_req`=1. `intr_id` stays frozen even if a higher-priority source arrives.
  - REQ -> SERVICE on `intr_ack`. `pending[intr_id]` is cleared on the same edge.
  - REQ -> IDLE if `intr_en`=0 or `mask[intr_id]`=0 without ack. The request is withdrawn and pending is kept.
  - SERVICE: `intr_req`=0 and `intr_id` holds. No nesting.
  - SERVICE -> IDLE on `intr_done`.
- `intr_ack` outside REQ is ignored. `intr_done` outside SERVICE is ignored.
- Reset asserted mid-handshake returns all state to reset values in the next cycle, regardless of ack/done.

## Timing
- `src_pulse[i]` high at edge t gives `pending[i]`=1 after edge t. `intr_req`=1 after edge t+1, so request latency is 2 cycles.
- Ack sampled at edge t gives `intr_req`=0 and `pending` cleared after edge t.
- Done at edge t returns to IDLE after t. A waiting candidate raises `intr_req` after t+1, giving a minimum 1-cycle gap.
- `intr_req` and `intr_id` are registered outputs with no combinational path from inputs.

## Configuration
- `INTR_TIMER_EN` defined:
  - A TIMER_W up-counter increments each cycle while period≠0.
  - When count == period−1 it wraps to 0 and ORs a one-cycle pulse into source N_SRC−1.
  - `timer_we` loads the period and zeroes the count.
  - Period 0 stops the counter and holds it at 0.
- `INTR_TIMER_EN` undefined: no timer logic. `timer_we` and `timer_wdata` are ignored, and source N_SRC−1 comes only from `src_pulse`.

## Structure
- Shared package holds the FSM state enum (`INTR_IDLE`, `INTR_REQ`, `INTR_SERVICE`) and default constants `INTR_N_SRC` and `INTR_ID_W`.
- One sub-module: `intr_prio_enc`, a parameterised lowest-index priority encoder with valid output.

## Test plan
- After reset, mask=4'b1111, intr_en=1, pulse src 2 -> pending=4'b0100 next cycle, `intr_req`=1 with `intr_id`=2 one cycle later; ack -> pending=0, req=0; done -> IDLE.
- Pulse src 3 and src 1 in the same cycle -> `intr_id`=1 served first. After done, `intr_id`=3 requested 2 cycles after done.
- mask=4'b0000, pulse src 0 -> pending=4'b0001, no req. Write mask=4'b0001 -> req with id 0 two cycles later.
- intr_en=0 with pending src 1 -> no req. Set intr_en=1 -> req, then drop intr_en before ack -> req withdrawn, pending[1] stays 1.
- In REQ for id 2, pulse src 2 in the ack cycle -> pending[2] remains 1 after ack. Assert reset during SERVICE -> all outputs 0 next cycle.
- With `INTR_TIMER_EN`, write period=10, mask[3]=1 -> pending[3] set every 10 cycles. Write period=0 -> no further pulses.
